// File: rtl/decodifica_soma_pkg.sv
// soma_pkg: shared constants and types for the soma offset-code receive path.
//   CODE_W / DATA_W      : code and decoded data widths
//   CODE_*_MIN/MAX       : legal code windows (unsigned)
//   POS_OFF / NEG_OFF    : offsets removed/added when decoding
//   LAST_BIT             : bit-counter value of the final serial bit
//   out_state_t          : output register occupancy
package soma_pkg;

   localparam int CODE_W = 5;
   localparam int DATA_W = 4;

   localparam logic [CODE_W-1:0] CODE_POS_MIN = 5'd3;
   localparam logic [CODE_W-1:0] CODE_POS_MAX = 5'd10;
   localparam logic [CODE_W-1:0] CODE_NEG_MIN = 5'd22;
   localparam logic [CODE_W-1:0] CODE_NEG_MAX = 5'd29;

   localparam logic [CODE_W-1:0] POS_OFF = 5'd3;
   localparam logic [CODE_W-1:0] NEG_OFF = 5'd2;

   localparam logic [2:0] LAST_BIT = 3'd4;

   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} out_state_t;

endpackage

// File: rtl/decodifica_soma_if.sv
// decodifica_soma_if: serial input and decoded output handshakes.
//   in_valid/in_ready/in_bit          : serial code bits, LSB first
//   out_valid/out_ready/out_data/err  : decoded symbol
//   slave  : decoder side
//   master : producer/consumer side
interface decodifica_soma_if;

   logic                        in_valid;
   logic                        in_ready;
   logic                        in_bit;
   logic                        out_valid;
   logic                        out_ready;
   logic [soma_pkg::DATA_W-1:0] out_data;
   logic                        out_err;

   modport slave (
      input  in_valid, in_bit, out_ready,
      output in_ready, out_valid, out_data, out_err
   );

   modport master (
      output in_valid, in_bit, out_ready,
      input  in_ready, out_valid, out_data, out_err
   );

endinterface

// File: rtl/decodifica_soma_decod_simb.sv
// decod_simb: combinational decoder of one 5-bit soma code.
//   code : 5-bit code, unsigned
//   data : recovered 4-bit signed value (0 on illegal code)
//   err  : code is outside both legal windows
module decod_simb
   import soma_pkg::*;
(
   input  logic [CODE_W-1:0] code,
   output logic [DATA_W-1:0] data,
   output logic              err
);

   logic [CODE_W-1:0] sum;

   always_comb begin
      err  = 1'b1;
      data = '0;
      sum  = '0;
      if (code >= CODE_POS_MIN && code <= CODE_POS_MAX) begin
         err  = 1'b0;
         sum  = code - POS_OFF;
         data = sum[DATA_W-1:0];
      end else if (code >= CODE_NEG_MIN && code <= CODE_NEG_MAX) begin
         // c+2 wraps mod 32; the low nibble is the negative value
         err  = 1'b0;
         sum  = code + NEG_OFF;
         data = sum[DATA_W-1:0];
      end
   end

endmodule

// File: rtl/decodifica_soma.sv
// decodifica_soma: bit-serial soma code decoder with error counter.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : serial input / decoded output handshakes (slave)
//   clr_err    : synchronous clear of err_count (wins over increment)
//   err_count  : saturating count of illegal codes
module decodifica_soma
   import soma_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   decodifica_soma_if.slave   bus,
   input  logic               clr_err,
   output logic [CNT_W-1:0]   err_count
);

   logic [2:0]        cnt;
   logic [CODE_W-1:0] sh;
   out_state_t        st;
   logic [DATA_W-1:0] data_q;
   logic              err_q;

   logic              xfer;
   logic              done;
   logic [CODE_W-1:0] code;
   logic [DATA_W-1:0] dec_data;
   logic              dec_err;

   // Only the final bit can stall, and only while the held symbol is unread
   assign bus.in_ready = !(cnt == LAST_BIT && st == FULL && !bus.out_ready);
   assign xfer         = bus.in_valid && bus.in_ready;
   assign done         = xfer && (cnt == LAST_BIT);
   // Decode uses the live bit as bit 4 so the symbol lands on the same edge
   assign code         = {bus.in_bit, sh[3:0]};

   decod_simb u_decod (
      .code (code),
      .data (dec_data),
      .err  (dec_err)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
         sh  <= '0;
      end else if (xfer) begin
         sh[cnt] <= bus.in_bit;
         cnt     <= done ? 3'd0 : cnt + 3'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st     <= EMPTY;
         data_q <= '0;
         err_q  <= 1'b0;
      end else begin
         case (st)
            EMPTY: begin
               if (done) begin
                  st     <= FULL;
                  data_q <= dec_data;
                  err_q  <= dec_err;
               end
            end
            FULL: begin
               // done while FULL implies out_ready (in_ready gates it)
               if (done) begin
                  data_q <= dec_data;
                  err_q  <= dec_err;
               end else if (bus.out_ready) begin
                  st <= EMPTY;
               end
            end
            default: st <= EMPTY;
         endcase
      end
   end

   assign bus.out_valid = (st == FULL);
   assign bus.out_data  = data_q;
   assign bus.out_err   = err_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_count <= '0;
      end else if (clr_err) begin
         err_count <= '0;
      end else if (done && dec_err && err_count != '1) begin
         err_count <= err_count + CNT_W'(1);
      end
   end

endmodule

// File: doc/decodifica_soma.md
# decodifica_soma

Bit-serial decoder for the 5-bit signed offset code produced by the team's `soma` encoder, where a 4-bit signed value x maps to x+3 if x≥0 and x−2 if x<0. It sits on the receive side of the link. It:
- deserialises 5-bit codes sent LSB-first,
- recovers the original 4-bit signed value,
- flags codes the encoder can never produce,
- keeps a saturating count of those errors.

Input and output each use a valid/ready handshake.

## Interface
- CNT_W, 8, width of the error counter
- clk  input  1  clock; all state changes on its rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  in_bit is valid this cycle
- in_ready  output  1  decoder accepts in_bit this cycle
- in_bit  input  1  serial code bit, LSB first
- out_valid  output  1  out_data and out_err hold a decoded symbol
- out_ready  input  1  consumer takes the symbol this cycle
- out_data  output  4  decoded value, signed two's complement
- out_err  output  1  symbol was an illegal code
- clr_err  input  1  synchronous clear of err_count
- err_count  output  CNT_W  saturating count of illegal codes

Clock and reset are fixed: one clock, asynchronous active-low reset.

## Operation
**Deserialiser**
- 5-bit shift register plus a 3-bit bit counter `cnt` (0..4).
- A transfer happens when in_valid && in_ready.
- On a transfer, in_bit is written to position `cnt`, then `cnt` advances.
- When the transfer is the 5th bit (`cnt`==4), `cnt` wraps to 0 and the full code is decoded in the same cycle, using the stored bits [3:0] plus in_bit as bit 4.

**Decode rule** (code c, 5 bits):
- Legal codes are c ∈ 3..10 and c ∈ 22..29, taken as unsigned.
- If c[4]==0: out_data = c−3, giving 0..7.
- If c[4]==1: out_data = c+2 mod 32, truncated to 4 bits, giving −8..−1.
- Any other code: out_err=1, out_data=0.

**Output register** (states EMPTY/FULL, shown by out_valid)
- EMPTY→FULL when a decode completes.
- FULL→EMPTY when out_ready is high and no new decode completes in the same cycle.
- FULL stays FULL and reloads when out_ready is high and a new decode completes in the same cycle.
- FULL with out_ready low keeps out_data and out_err stable.

**in_ready**
- in_ready = !(cnt==4 && out_valid && !out_ready).
- In words: only the 5th bit can stall, and only while the previous symbol is still held.

**Error counter**
- Increments by 1 on each completed decode with out_err=1.
- Saturates at 2^CNT_W−1.
- clr_err sets it to 0. clr_err has priority over an increment in the same cycle.

## Timing
**Reset values** (while rst_n=0):
- out_valid=0, out_data=0, out_err=0, err_count=0
- cnt=0, shift register=0
- in_ready=1

**Reset behaviour**
- Deasserting rst_n mid-frame discards the partial code. The next accepted bit is treated as bit 0.

**Latency and throughput**
- out_valid rises on the edge that accepts the 5th bit, so it is visible the cycle after that bit was presented.
- err_count updates on the same edge.
- Sustained throughput is one symbol per 5 cycles.
- Because of that throughput, out_ready low for up to 4 cycles never stalls the input.

**Boundary conditions**
- Idle cycles (in_valid=0) between bits are allowed. Frame position is kept.
- A symbol held in FULL is never overwritten without out_ready.

## Structure
**Package `soma_pkg`**
- Code constants: CODE_POS_MIN=3, CODE_POS_MAX=10, CODE_NEG_MIN=22, CODE_NEG_MAX=29.
- Offsets: POS_OFF=3, NEG_OFF=2.
- Widths: CODE_W=5, DATA_W=4.

**Sub-module `decod_simb`**
- Combinational.
- 5-bit code in; 4-bit data and err out.
- Reusable by the parallel receive path.

The top level holds the counter, shift register, output register and error counter.

## Test plan
- Reset, then send code 3 (bits 1,1,0,0,0) with out_ready=1 → out_valid for 1 cycle, out_data=0, out_err=0.
- Send codes 10, 22, 29 back-to-back → out_data = 7, −8, −1 respectively; in_ready stays 1 throughout.
- Send codes 0, 11, 31 → out_err=1 and out_data=0 each time; err_count reaches 3. Then pulse clr_err in the same cycle as a 4th illegal code completes → err_count=0.
- Hold out_ready=0 for 12 cycles while streaming codes 4, then 5:
  - symbol 1 (out_data=1) stays stable;
  - in_ready drops while the 5th bit of code 5 is presented;
  - raising out_ready delivers 1 then 2, with no loss.
- Assert rst_n=0 after 3 bits of a frame, release, then send code 7 → out_data=4. No symbol is emitted from the aborted frame.
- Exhaustive run of all 32 codes:
  - compare against the inverse of the encoder rule;
  - legal codes give exact values;
  - the 16 illegal codes give out_err=1;
  - err_count=16 at the end.
